// File: rtl/onchip_mem_arb_pkg.sv
// Shared types for the on-chip RAM arbiter: FSM state encoding, default
// bus widths and the owner (master index) type used by the grant logic and
// the read-return tag.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Master index: 0 or 1.
  typedef logic owner_t;

  function automatic owner_t other(input owner_t o);
    return ~o;
  endfunction

endpackage

// File: rtl/onchip_mem_arb_rr.sv
// 2-way round-robin picker.
// Ports:
//   req[1:0]     per-master request
//   rr_ptr       master that wins when both request
//   force_en     restrict grant to force_owner (lock held)
//   force_owner  the only master allowed while force_en is set
//   grant[1:0]   one-hot grant, zero when nobody eligible requests
module onchip_mem_arb_rr
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     rr_ptr,
  input  logic       force_en,
  input  owner_t     force_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (force_en)      grant[force_owner] = req[force_owner];
    else if (&req)     grant[rr_ptr]      = 1'b1;
    else               grant              = req;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM style masters.
// Round-robin grant, optional per-master lock for atomic sequences with an
// idle watchdog, one-cycle read return tagged with the owning master.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mN_*                  master N request side (address/byteenable/read/
//                         write/writedata/lock in, waitrequest/readdatavalid/
//                         readdata out)
//   mem_*                 RAM port; mem_readdata is valid one cycle after
//                         the address is presented
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BE_W         = DEF_BE_W,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  // +2 keeps the counter at least one bit wide even with the watchdog off.
  localparam int               CNT_W   = $clog2(LOCK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(LOCK_TIMEOUT);

  arb_state_e       state, state_n;
  owner_t           rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
  logic             rd_pend;
  owner_t           rd_owner;

  logic [1:0] req, grant;
  logic       accept, win_write, win_lock, force_en;
  owner_t     winner, lock_owner;

  assign req        = {m1_read | m1_write, m0_read | m0_write};
  assign force_en   = (state != ARB);
  assign lock_owner = (state == LOCK1);

  onchip_mem_arb_rr u_rr (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .force_en    (force_en),
    .force_owner (lock_owner),
    .grant       (grant)
  );

  assign accept    = |grant;
  assign winner    = grant[1];
  assign win_write = winner ? m1_write : m0_write;
  assign win_lock  = winner ? m1_lock  : m0_lock;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  // Next state. idle_cnt defaults to 0 so any request from the lock owner
  // (which is always granted while locked) clears it.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    idle_cnt_n = '0;
    if (accept) rr_ptr_n = other(winner);
    unique case (state)
      ARB: begin
        // Only the accepted transfer's lock is sampled, so a waiting
        // master's lock, or the loser's in a tie, has no effect.
        if (accept && win_lock) state_n = winner ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (accept) begin
          if (!win_lock) state_n = ARB;
        end else if (LOCK_TIMEOUT != 0) begin
          idle_cnt_n = idle_cnt + CNT_W'(1);
          // Silent force-release: the other master gets first turn.
          if (idle_cnt_n == TIMEOUT) begin
            state_n    = ARB;
            rr_ptr_n   = other(lock_owner);
            idle_cnt_n = '0;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= 1'b0;
      idle_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      idle_cnt <= idle_cnt_n;
      rd_pend  <= accept & ~win_write;
      rd_owner <= winner;
    end
  end

  // RAM drive only in the accepting cycle; reads use all byte lanes.
  always_comb begin
    mem_chipselect = accept;
    mem_write      = accept & win_write;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (accept) begin
      mem_address    = winner ? m1_address   : m0_address;
      mem_writedata  = winner ? m1_writedata : m0_writedata;
      mem_byteenable = win_write ? (winner ? m1_byteenable : m0_byteenable) : '1;
    end
  end

  // Gating with reset drops a return still in flight when reset arrives.
  assign m0_readdatavalid = rd_pend & (rd_owner == 1'b0) & ~reset;
  assign m1_readdatavalid = rd_pend & (rd_owner == 1'b1) & ~reset;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule
